// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/IO arbiter: IO register offsets and FSM states.
package mem_io_pkg;

  // Register offsets relative to IO_BASE
  localparam int unsigned CHG_OFS  = 'h10;
  localparam int unsigned MASK_OFS = 'h11;
  localparam int unsigned OUT_OFS  = 'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IO_ACC = 2'd1,
    MEM_WR = 2'd2,
    MEM_RD = 2'd3
  } state_t;

endpackage

// File: rtl/mem_io_arbiter_sync.sv
// One input channel: 2-FF synchroniser plus a history register for change detection.
module io_sync_chan #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] din,
  output logic [IN_W-1:0] sync_val,
  output logic            chg_pulse
);

  logic [IN_W-1:0] meta_q;
  logic [IN_W-1:0] sync_q;
  logic [IN_W-1:0] prev_q;

  // Synchronise the asynchronous input and keep the previous synchronised value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_val  = sync_q;
  assign chg_pulse = (sync_q != prev_q);

endmodule

// File: rtl/mem_io_arbiter.sv
// Routes CPU load/store accesses either to BRAM port A or to memory-mapped IO
// registers (input channels with change flags, IRQ mask, output registers).
//
// state  | meaning
// IDLE   | waiting for cpu_req; IO registers are read/written on the accepting edge
// IO_ACC | IO access done, cpu_ack high for this one cycle
// MEM_WR | mem_we and cpu_ack high for this one cycle
// MEM_RD | mem_addr held while BRAM latency counts down; last cycle carries cpu_ack
module mem_io_arbiter
  import mem_io_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IO_BASE  = 16'hFF00,
  parameter int                NUM_IN   = 4,
  parameter int                IN_W     = 8,
  parameter int                NUM_OUT  = 4,
  parameter int                BRAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_ack,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic [NUM_IN*IN_W-1:0]    io_in,
  output logic [NUM_OUT*DATA_W-1:0] io_out,
  output logic                      io_irq
);

  localparam int CNT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [NUM_IN-1:0] chg_flags;
  logic [NUM_IN-1:0] irq_mask;
  logic [NUM_IN-1:0] chg_pulse;
  logic [IN_W-1:0]   sync_val [NUM_IN];
  logic [ADDR_W-1:0] io_ofs;
  logic              is_io;
  logic              io_wr;
  logic [DATA_W-1:0] io_rd;
  logic [NUM_IN-1:0] w1c;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
    io_sync_chan #(.IN_W(IN_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .din       (io_in[i*IN_W +: IN_W]),
      .sync_val  (sync_val[i]),
      .chg_pulse (chg_pulse[i])
    );
  end

  // Unsigned wrap-around is harmless: offsets are only used when is_io holds.
  assign io_ofs = cpu_addr - IO_BASE;
  assign is_io  = (cpu_addr >= IO_BASE);
  assign io_wr  = (state == IDLE) && cpu_req && is_io && cpu_we;
  assign w1c    = (io_wr && io_ofs == ADDR_W'(CHG_OFS)) ? cpu_wdata[NUM_IN-1:0] : '0;

  // IO read mux; unmapped offsets fall through to zero
  always_comb begin
    io_rd = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (io_ofs == ADDR_W'(i)) io_rd = DATA_W'(sync_val[i]);
    end
    if (io_ofs == ADDR_W'(CHG_OFS))  io_rd = DATA_W'(chg_flags);
    if (io_ofs == ADDR_W'(MASK_OFS)) io_rd = DATA_W'(irq_mask);
    for (int j = 0; j < NUM_OUT; j++) begin
      if (io_ofs == ADDR_W'(OUT_OFS) + ADDR_W'(j)) io_rd = io_out[j*DATA_W +: DATA_W];
    end
  end

  // Change flags (a new change beats a same-cycle clear), IRQ mask and registered IRQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_flags <= '0;
      irq_mask  <= '0;
      io_irq    <= 1'b0;
    end else begin
      chg_flags <= (chg_flags & ~w1c) | chg_pulse;
      if (io_wr && io_ofs == ADDR_W'(MASK_OFS)) irq_mask <= cpu_wdata[NUM_IN-1:0];
      io_irq <= |(chg_flags & irq_mask);
    end
  end

  // Output registers written on the accepting edge of an IO store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (io_wr && io_ofs == ADDR_W'(OUT_OFS) + ADDR_W'(j)) io_out[j*DATA_W +: DATA_W] <= cpu_wdata;
      end
    end
  end

  // Transaction sequencer with registered handshake and BRAM strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      rdata_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            if (is_io) begin
              rdata_q <= io_rd;
              cpu_ack <= 1'b1;
              state   <= IO_ACC;
            end else if (cpu_we) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_we    <= 1'b1;
              cpu_ack   <= 1'b1;
              state     <= MEM_WR;
            end else begin
              mem_addr <= cpu_addr;
              lat_cnt  <= CNT_W'(BRAM_LAT - 1);
              state    <= MEM_RD;
            end
          end
        end
        IO_ACC, MEM_WR: begin
          cpu_ack <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
        MEM_RD: begin
          if (cpu_ack) begin
            cpu_ack <= 1'b0;
            state   <= IDLE;
          end else if (lat_cnt == '0) begin
            cpu_ack <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load data comes straight from BRAM in the MEM_RD ack cycle, so the load
  // completes BRAM_LAT+1 cycles after the request; IO data is registered.
  assign cpu_rdata = (state == MEM_RD) ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Self-checking bench for mem_io_arbiter with a behavioural BRAM and IO model.
module tb_mem_io_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int NUM_IN   = 4;
  localparam int IN_W     = 8;
  localparam int NUM_OUT  = 4;
  localparam int BRAM_LAT = 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      cpu_req = 1'b0;
  logic                      cpu_we = 1'b0;
  logic [ADDR_W-1:0]         cpu_addr = '0;
  logic [DATA_W-1:0]         cpu_wdata = '0;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ack;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_IN*IN_W-1:0]    io_in = '0;
  logic [NUM_OUT*DATA_W-1:0] io_out;
  logic                      io_irq;

  int n_cmp = 0;
  int n_err = 0;

  mem_io_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_BASE(16'hFF00), .NUM_IN(NUM_IN),
    .IN_W(IN_W), .NUM_OUT(NUM_OUT), .BRAM_LAT(BRAM_LAT)
  ) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .io_in(io_in),
    .io_out(io_out), .io_irq(io_irq)
  );

  always #5 clk = ~clk;

  // BRAM with one cycle of read latency
  logic [15:0] bram [0:1023];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[9:0]];
  end

  // Event monitors
  int          ack_cnt = 0;
  int          ack_dbl = 0;
  int          we_cnt = 0;
  logic        ack_prev = 1'b0;
  logic [15:0] last_we_addr = '0;
  logic [15:0] last_we_data = '0;
  always @(posedge clk) begin
    if (cpu_ack) ack_cnt++;
    if (cpu_ack && ack_prev) ack_dbl++;
    ack_prev = cpu_ack;
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  // Reference model state
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] mem_addrs [$];
  logic [7:0]  chan_model [NUM_IN];
  logic [3:0]  flag_model = '0;
  logic [63:0] out_model = '0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for the bus to be idle, issues one access and waits for its ack
  task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0;
    rdata = 'x;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_ack) begin
        rdata = cpu_rdata;
        break;
      end
    end
    if (!cpu_ack) begin
      n_cmp++; n_err++;
      $display("FAIL access_timeout addr=%h: no ack seen, required ack within 20 cycles", addr);
      lat = -1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic set_chan(input int i, input logic [7:0] v);
    if (v != chan_model[i]) flag_model[i] = 1'b1;
    chan_model[i] = v;
    io_in[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    logic [15:0] r; int lat;
    for (int i = 0; i < NUM_IN; i++) chan_model[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b exp=0", cpu_ack); end
    n_cmp++; if (cpu_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0000", cpu_rdata); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_cmp++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_mem_bus got=%h/%h exp=0000/0000", mem_addr, mem_wdata); end
    n_cmp++; if (io_out !== 64'h0) begin n_err++; $display("FAIL reset_io_out got=%h exp=0", io_out); end
    n_cmp++; if (io_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", io_irq); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0) begin n_err++; $display("FAIL reset_flags got=%h exp=0000", r); end
    cpu_access(1'b0, 16'hFF11, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0) begin n_err++; $display("FAIL reset_mask got=%h exp=0000", r); end
  endtask

  task automatic test_mem();
    logic [15:0] r, a, d; int lat, we0, k;
    we0 = we_cnt;
    cpu_access(1'b1, 16'h0040, 16'h1234, r, lat);
    mem_model[16'h0040] = 16'h1234; mem_addrs.push_back(16'h0040);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL store_latency got=%0d exp=1", lat); end
    @(posedge clk); #1;
    n_cmp++; if (we_cnt - we0 != 1 || last_we_addr !== 16'h0040 || last_we_data !== 16'h1234) begin
      n_err++; $display("FAIL store_pulse got=%0d pulses addr=%h data=%h exp=1 pulse addr=0040 data=1234", we_cnt - we0, last_we_addr, last_we_data); end
    cpu_access(1'b0, 16'h0040, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h1234) begin n_err++; $display("FAIL load_data got=%h exp=1234", r); end
    n_cmp++; if (lat != BRAM_LAT + 1) begin n_err++; $display("FAIL load_latency got=%0d exp=%0d", lat, BRAM_LAT + 1); end
    n_cmp++; if (we_cnt - we0 != 1) begin n_err++; $display("FAIL load_no_we got=%0d pulses exp=1", we_cnt - we0); end
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(1) == 1) begin
        a = 16'($urandom_range(16'h3FF)); d = 16'($urandom);
        cpu_access(1'b1, a, d, r, lat);
        if (!mem_model.exists(a)) mem_addrs.push_back(a);
        mem_model[a] = d;
      end else begin
        k = $urandom_range(mem_addrs.size() - 1);
        a = mem_addrs[k];
        cpu_access(1'b0, a, 16'h0, r, lat);
        n_cmp++; if (r !== mem_model[a] || lat != BRAM_LAT + 1) begin
          n_err++; $display("FAIL rand_load addr=%h got=%h lat=%0d exp=%h lat=%0d", a, r, lat, mem_model[a], BRAM_LAT + 1); end
      end
    end
  endtask

  task automatic test_io_in();
    logic [15:0] r; int lat, we0;
    logic [7:0] v;
    we0 = we_cnt;
    set_chan(2, 8'hA5);
    repeat (3) @(posedge clk);
    cpu_access(1'b0, 16'hFF02, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h00A5 || lat != 1) begin n_err++; $display("FAIL chan2_read got=%h lat=%0d exp=00a5 lat=1", r, lat); end
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'(flag_model)) begin n_err++; $display("FAIL chg_flags got=%h exp=%h", r, 16'(flag_model)); end
    cpu_access(1'b1, 16'hFF10, 16'h0004, r, lat);
    flag_model = flag_model & ~4'h4;
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0) begin n_err++; $display("FAIL w1c_clear got=%h exp=0000", r); end
    n_cmp++; if (we_cnt != we0) begin n_err++; $display("FAIL io_no_mem_we got=%0d pulses exp=0", we_cnt - we0); end
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        v = ($urandom_range(2) == 0) ? chan_model[i] : 8'($urandom);
        set_chan(i, v);
      end
      repeat (4) @(posedge clk);
      for (int i = 0; i < NUM_IN; i++) begin
        cpu_access(1'b0, 16'hFF00 + 16'(i), 16'h0, r, lat);
        n_cmp++; if (r !== {8'h00, chan_model[i]}) begin n_err++; $display("FAIL rand_chan%0d got=%h exp=%h", i, r, {8'h00, chan_model[i]}); end
      end
      cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
      n_cmp++; if (r !== 16'(flag_model)) begin n_err++; $display("FAIL rand_flags got=%h exp=%h", r, 16'(flag_model)); end
      cpu_access(1'b1, 16'hFF10, 16'h000F, r, lat);
      flag_model = '0;
    end
  endtask

  task automatic test_irq();
    logic [15:0] r; int lat, cyc;
    cpu_access(1'b1, 16'hFF11, 16'h0002, r, lat);
    cpu_access(1'b0, 16'hFF11, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0002) begin n_err++; $display("FAIL mask_read got=%h exp=0002", r); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (io_irq !== 1'b0) begin n_err++; $display("FAIL irq_idle got=%b exp=0", io_irq); end
    set_chan(1, chan_model[1] ^ 8'h3C);
    cyc = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (io_irq === 1'b1) break;
    end
    n_cmp++; if (io_irq !== 1'b1 || cyc > 4) begin n_err++; $display("FAIL irq_rise got=%b after %0d cycles exp=1 within 4", io_irq, cyc); end
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0002) begin n_err++; $display("FAIL irq_flag got=%h exp=0002", r); end
    // New ch1 change whose flag-set edge coincides with the W1C accept edge
    set_chan(1, chan_model[1] ^ 8'h01);
    @(posedge clk); #1;
    cpu_access(1'b1, 16'hFF10, 16'h0002, r, lat);
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0002) begin n_err++; $display("FAIL set_beats_clear got=%h exp=0002", r); end
    n_cmp++; if (io_irq !== 1'b1) begin n_err++; $display("FAIL irq_held got=%b exp=1", io_irq); end
    cpu_access(1'b1, 16'hFF10, 16'h0002, r, lat);
    flag_model = '0;
    cpu_access(1'b0, 16'hFF10, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0) begin n_err++; $display("FAIL plain_clear got=%h exp=0000", r); end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (io_irq !== 1'b0) begin n_err++; $display("FAIL irq_fall got=%b exp=0", io_irq); end
  endtask

  task automatic test_io_out();
    logic [15:0] r, d; int lat, we0, j;
    we0 = we_cnt;
    cpu_access(1'b1, 16'hFF23, 16'hBEEF, r, lat);
    out_model[3*16 +: 16] = 16'hBEEF;
    @(posedge clk); #1;
    n_cmp++; if (io_out[3*16 +: 16] !== 16'hBEEF) begin n_err++; $display("FAIL out3_write got=%h exp=beef", io_out[3*16 +: 16]); end
    n_cmp++; if (we_cnt != we0) begin n_err++; $display("FAIL out3_no_mem_we got=%0d pulses exp=0", we_cnt - we0); end
    cpu_access(1'b0, 16'hFF23, 16'h0, r, lat);
    n_cmp++; if (r !== 16'hBEEF) begin n_err++; $display("FAIL out3_read got=%h exp=beef", r); end
    cpu_access(1'b0, 16'hFF50, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h0 || lat != 1) begin n_err++; $display("FAIL unmapped_read got=%h lat=%0d exp=0000 lat=1", r, lat); end
    cpu_access(1'b1, 16'hFF50, 16'h5A5A, r, lat);
    n_cmp++; if (io_out !== out_model || lat != 1) begin n_err++; $display("FAIL unmapped_write got=%h lat=%0d exp=%h lat=1", io_out, lat, out_model); end
    for (int n = 0; n < 8; n++) begin
      j = $urandom_range(NUM_OUT - 1);
      d = 16'($urandom);
      cpu_access(1'b1, 16'hFF20 + 16'(j), d, r, lat);
      out_model[j*16 +: 16] = d;
      @(posedge clk); #1;
      n_cmp++; if (io_out !== out_model) begin n_err++; $display("FAIL rand_out got=%h exp=%h", io_out, out_model); end
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      cpu_access(1'b0, 16'hFF20 + 16'(k), 16'h0, r, lat);
      n_cmp++; if (r !== out_model[k*16 +: 16]) begin n_err++; $display("FAIL out%0d_read got=%h exp=%h", k, r, out_model[k*16 +: 16]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, a0, a1; int lat, ack0, first, second, cyc;
    logic [15:0] d0, d1;
    a0 = 16'h0200; a1 = 16'h0201;
    cpu_access(1'b1, a0, 16'hC0DE, r, lat); mem_model[a0] = 16'hC0DE;
    cpu_access(1'b1, a1, 16'h7E57, r, lat); mem_model[a1] = 16'h7E57;
    @(posedge clk); #1;
    ack0 = ack_cnt;
    ack_dbl = 0;
    first = -1; second = -1; d0 = 'x; d1 = 'x;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a0;
    cyc = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack) begin
        if (first < 0) begin
          first = cyc; d0 = cpu_rdata; cpu_addr = a1;
        end else begin
          second = cyc; d1 = cpu_rdata;
          break;
        end
      end
    end
    cpu_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (d0 !== mem_model[a0] || first != BRAM_LAT + 1) begin n_err++; $display("FAIL b2b_first got=%h at %0d exp=%h at %0d", d0, first, mem_model[a0], BRAM_LAT + 1); end
    n_cmp++; if (d1 !== mem_model[a1] || second - first != BRAM_LAT + 2) begin n_err++; $display("FAIL b2b_second got=%h gap=%0d exp=%h gap=%0d", d1, second - first, mem_model[a1], BRAM_LAT + 2); end
    n_cmp++; if (ack_cnt - ack0 != 2 || ack_dbl != 0) begin n_err++; $display("FAIL b2b_acks got=%0d acks %0d overlaps exp=2 acks 0 overlaps", ack_cnt - ack0, ack_dbl); end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] r; int lat, ack0, we0, cyc;
    cpu_access(1'b1, 16'h0100, 16'h4242, r, lat); mem_model[16'h0100] = 16'h4242;
    set_chan(1, chan_model[1] ^ 8'h80);
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (io_irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq got=%b exp=1", io_irq); end
    @(posedge clk); #1;
    ack0 = ack_cnt; we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    n_cmp++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0 || io_irq !== 1'b0 || io_out !== 64'h0 || cpu_rdata !== 16'h0) begin
      n_err++; $display("FAIL midrd_reset got=ack%b we%b irq%b out%h rd%h exp=all zero", cpu_ack, mem_we, io_irq, io_out, cpu_rdata); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    flag_model = '0; out_model = '0;
    repeat (6) @(posedge clk); #1;
    n_cmp++; if (ack_cnt != ack0 || we_cnt != we0) begin n_err++; $display("FAIL midrd_aborted got=%0d acks %0d writes exp=0 acks 0 writes", ack_cnt - ack0, we_cnt - we0); end
    n_cmp++; if (io_irq !== 1'b0 || io_out !== 64'h0) begin n_err++; $display("FAIL midrd_after got=irq%b out%h exp=irq0 out0", io_irq, io_out); end
    cyc = ack_cnt;
    cpu_access(1'b0, 16'h0100, 16'h0, r, lat);
    n_cmp++; if (r !== 16'h4242 || lat != BRAM_LAT + 1 || ack_cnt - cyc > 1) begin n_err++; $display("FAIL midrd_recover got=%h lat=%0d exp=4242 lat=%0d", r, lat, BRAM_LAT + 1); end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_io_in();
    test_irq();
    test_io_out();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
